alu_reservation_station: RTL and testbench

- Buffers dispatched arithmetic, logic, branch and jump instructions until both source operands are available, then issues one ready instruction per cycle to the combinational ALU.
- Sits between the dispatcher (upstream) and the ALU (downstream).
- Snoops the ALU and LSB broadcast buses to wake up waiting operands.
- Flushed by the reorder buffer on misprediction.

---
 rtl/alu_reservation_station.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_reservation_station.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU/branch/jump instructions until
// both operands are available, snoops the ALU and LSB result buses for
// wakeup, and issues the lowest-index ready entry once per cycle.
module alu_reservation_station #(
  parameter int RS_SIZE  = 8,
  parameter int RS_IDX_W = 3,
  parameter int WORD_W   = 32,
  parameter int TAG_W    = 4,
  parameter int OP_W     = 6
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              rob_clear_in,
  input  logic              dispatch_signal_in,
  input  logic [OP_W-1:0]   dispatch_op_in,
  input  logic [WORD_W-1:0] dispatch_imm_in,
  input  logic [WORD_W-1:0] dispatch_pc_in,
  input  logic              dispatch_rs1_ready_in,
  input  logic [WORD_W-1:0] dispatch_rs1val_in,
  input  logic [TAG_W-1:0]  dispatch_rs1tag_in,
  input  logic              dispatch_rs2_ready_in,
  input  logic [WORD_W-1:0] dispatch_rs2val_in,
  input  logic [TAG_W-1:0]  dispatch_rs2tag_in,
  input  logic [TAG_W-1:0]  dispatch_dest_in,
  output logic              full_out,
  input  logic              alu_broadcast_signal_in,
  input  logic [WORD_W-1:0] alu_result_in,
  input  logic [TAG_W-1:0]  alu_dest_tag_in,
  input  logic              lsb_broadcast_signal_in,
  input  logic [WORD_W-1:0] lsb_result_in,
  input  logic [TAG_W-1:0]  lsb_dest_tag_in,
  output logic              alu_calculate_signal_out,
  output logic [OP_W-1:0]   alu_op_out,
  output logic [WORD_W-1:0] alu_imm_out,
  output logic [WORD_W-1:0] alu_pc_out,
  output logic [WORD_W-1:0] alu_rs1val_out,
  output logic [WORD_W-1:0] alu_rs2val_out,
  output logic [TAG_W-1:0]  alu_dest_out
);

  // Entry storage
  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [RS_SIZE-1:0] q1_q, q1_d;
  logic [RS_SIZE-1:0] q2_q, q2_d;
  logic [OP_W-1:0]    op_q   [RS_SIZE];
  logic [OP_W-1:0]    op_d   [RS_SIZE];
  logic [WORD_W-1:0]  imm_q  [RS_SIZE];
  logic [WORD_W-1:0]  imm_d  [RS_SIZE];
  logic [WORD_W-1:0]  pc_q   [RS_SIZE];
  logic [WORD_W-1:0]  pc_d   [RS_SIZE];
  logic [WORD_W-1:0]  v1_q   [RS_SIZE];
  logic [WORD_W-1:0]  v1_d   [RS_SIZE];
  logic [WORD_W-1:0]  v2_q   [RS_SIZE];
  logic [WORD_W-1:0]  v2_d   [RS_SIZE];
  logic [TAG_W-1:0]   t1_q   [RS_SIZE];
  logic [TAG_W-1:0]   t1_d   [RS_SIZE];
  logic [TAG_W-1:0]   t2_q   [RS_SIZE];
  logic [TAG_W-1:0]   t2_d   [RS_SIZE];
  logic [TAG_W-1:0]   dest_q [RS_SIZE];
  logic [TAG_W-1:0]   dest_d [RS_SIZE];

  // Issue output registers
  logic              calc_q, calc_d;
  logic [OP_W-1:0]   out_op_q, out_op_d;
  logic [WORD_W-1:0] out_imm_q, out_imm_d;
  logic [WORD_W-1:0] out_pc_q, out_pc_d;
  logic [WORD_W-1:0] out_v1_q, out_v1_d;
  logic [WORD_W-1:0] out_v2_q, out_v2_d;
  logic [TAG_W-1:0]  out_dest_q, out_dest_d;

  logic [RS_IDX_W-1:0] free_idx;
  logic [RS_IDX_W-1:0] sel_idx;
  logic                sel_found;

  // Resolve a not-ready operand against both result buses; ALU has priority.
  // Returns {ready, value}.
  function automatic logic [WORD_W:0] resolve(
    input logic              rdy,
    input logic [WORD_W-1:0] val,
    input logic [TAG_W-1:0]  tag,
    input logic              a_vld,
    input logic [TAG_W-1:0]  a_tag,
    input logic [WORD_W-1:0] a_val,
    input logic              l_vld,
    input logic [TAG_W-1:0]  l_tag,
    input logic [WORD_W-1:0] l_val
  );
    logic [WORD_W:0] r;
    r = {rdy, val};
    if (!rdy) begin
      if (a_vld && a_tag == tag)      r = {1'b1, a_val};
      else if (l_vld && l_tag == tag) r = {1'b1, l_val};
    end
    return r;
  endfunction

  assign full_out = &busy_q;

  assign alu_calculate_signal_out = calc_q;
  assign alu_op_out               = out_op_q;
  assign alu_imm_out              = out_imm_q;
  assign alu_pc_out               = out_pc_q;
  assign alu_rs1val_out           = out_v1_q;
  assign alu_rs2val_out           = out_v2_q;
  assign alu_dest_out             = out_dest_q;

  // Lowest free slot for dispatch and lowest ready busy slot for issue.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = RS_IDX_W'(i);
      if (busy_q[i] && q1_q[i] && q2_q[i]) begin
        sel_idx   = RS_IDX_W'(i);
        sel_found = 1'b1;
      end
    end
  end

  // Next-state: wakeup, issue, dispatch with bypass, flush.
  always_comb begin
    busy_d     = busy_q;
    q1_d       = q1_q;
    q2_d       = q2_q;
    op_d       = op_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    v1_d       = v1_q;
    v2_d       = v2_q;
    t1_d       = t1_q;
    t2_d       = t2_q;
    dest_d     = dest_q;
    calc_d     = 1'b0;
    out_op_d   = out_op_q;
    out_imm_d  = out_imm_q;
    out_pc_d   = out_pc_q;
    out_v1_d   = out_v1_q;
    out_v2_d   = out_v2_q;
    out_dest_d = out_dest_q;

    if (rdy_in) begin
      if (rob_clear_in) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i]) begin
            {q1_d[i], v1_d[i]} = resolve(q1_q[i], v1_q[i], t1_q[i],
              alu_broadcast_signal_in, alu_dest_tag_in, alu_result_in,
              lsb_broadcast_signal_in, lsb_dest_tag_in, lsb_result_in);
            {q2_d[i], v2_d[i]} = resolve(q2_q[i], v2_q[i], t2_q[i],
              alu_broadcast_signal_in, alu_dest_tag_in, alu_result_in,
              lsb_broadcast_signal_in, lsb_dest_tag_in, lsb_result_in);
          end
        end

        if (sel_found) begin
          busy_d[sel_idx] = 1'b0;
          calc_d          = 1'b1;
          out_op_d        = op_q[sel_idx];
          out_imm_d       = imm_q[sel_idx];
          out_pc_d        = pc_q[sel_idx];
          out_v1_d        = v1_q[sel_idx];
          out_v2_d        = v2_q[sel_idx];
          out_dest_d      = dest_q[sel_idx];
        end

        // The issued slot was busy before the edge, so free_idx never aliases it.
        if (dispatch_signal_in && !full_out) begin
          busy_d[free_idx] = 1'b1;
          op_d[free_idx]   = dispatch_op_in;
          imm_d[free_idx]  = dispatch_imm_in;
          pc_d[free_idx]   = dispatch_pc_in;
          t1_d[free_idx]   = dispatch_rs1tag_in;
          t2_d[free_idx]   = dispatch_rs2tag_in;
          dest_d[free_idx] = dispatch_dest_in;
          {q1_d[free_idx], v1_d[free_idx]} = resolve(dispatch_rs1_ready_in,
            dispatch_rs1val_in, dispatch_rs1tag_in,
            alu_broadcast_signal_in, alu_dest_tag_in, alu_result_in,
            lsb_broadcast_signal_in, lsb_dest_tag_in, lsb_result_in);
          {q2_d[free_idx], v2_d[free_idx]} = resolve(dispatch_rs2_ready_in,
            dispatch_rs2val_in, dispatch_rs2tag_in,
            alu_broadcast_signal_in, alu_dest_tag_in, alu_result_in,
            lsb_broadcast_signal_in, lsb_dest_tag_in, lsb_result_in);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q     <= '0;
      q1_q       <= '0;
      q2_q       <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]   <= '0;
        imm_q[i]  <= '0;
        pc_q[i]   <= '0;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        t1_q[i]   <= '0;
        t2_q[i]   <= '0;
        dest_q[i] <= '0;
      end
      calc_q     <= 1'b0;
      out_op_q   <= '0;
      out_imm_q  <= '0;
      out_pc_q   <= '0;
      out_v1_q   <= '0;
      out_v2_q   <= '0;
      out_dest_q <= '0;
    end else begin
      busy_q     <= busy_d;
      q1_q       <= q1_d;
      q2_q       <= q2_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      t1_q       <= t1_d;
      t2_q       <= t2_d;
      dest_q     <= dest_d;
      calc_q     <= calc_d;
      out_op_q   <= out_op_d;
      out_imm_q  <= out_imm_d;
      out_pc_q   <= out_pc_d;
      out_v1_q   <= out_v1_d;
      out_v2_q   <= out_v2_d;
      out_dest_q <= out_dest_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: table of single-cycle vectors
// followed by hand-written multi-cycle sequences (rdy, full, flush, reset).
module tb_alu_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        rob_clear_in;
  logic        dispatch_signal_in;
  logic [5:0]  dispatch_op_in;
  logic [31:0] dispatch_imm_in;
  logic [31:0] dispatch_pc_in;
  logic        dispatch_rs1_ready_in;
  logic [31:0] dispatch_rs1val_in;
  logic [3:0]  dispatch_rs1tag_in;
  logic        dispatch_rs2_ready_in;
  logic [31:0] dispatch_rs2val_in;
  logic [3:0]  dispatch_rs2tag_in;
  logic [3:0]  dispatch_dest_in;
  logic        full_out;
  logic        alu_broadcast_signal_in;
  logic [31:0] alu_result_in;
  logic [3:0]  alu_dest_tag_in;
  logic        lsb_broadcast_signal_in;
  logic [31:0] lsb_result_in;
  logic [3:0]  lsb_dest_tag_in;
  logic        alu_calculate_signal_out;
  logic [5:0]  alu_op_out;
  logic [31:0] alu_imm_out;
  logic [31:0] alu_pc_out;
  logic [31:0] alu_rs1val_out;
  logic [31:0] alu_rs2val_out;
  logic [3:0]  alu_dest_out;

  int errors = 0;
  int checks = 0;

  alu_reservation_station dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .rob_clear_in(rob_clear_in),
    .dispatch_signal_in(dispatch_signal_in), .dispatch_op_in(dispatch_op_in),
    .dispatch_imm_in(dispatch_imm_in), .dispatch_pc_in(dispatch_pc_in),
    .dispatch_rs1_ready_in(dispatch_rs1_ready_in), .dispatch_rs1val_in(dispatch_rs1val_in),
    .dispatch_rs1tag_in(dispatch_rs1tag_in), .dispatch_rs2_ready_in(dispatch_rs2_ready_in),
    .dispatch_rs2val_in(dispatch_rs2val_in), .dispatch_rs2tag_in(dispatch_rs2tag_in),
    .dispatch_dest_in(dispatch_dest_in), .full_out(full_out),
    .alu_broadcast_signal_in(alu_broadcast_signal_in), .alu_result_in(alu_result_in),
    .alu_dest_tag_in(alu_dest_tag_in), .lsb_broadcast_signal_in(lsb_broadcast_signal_in),
    .lsb_result_in(lsb_result_in), .lsb_dest_tag_in(lsb_dest_tag_in),
    .alu_calculate_signal_out(alu_calculate_signal_out), .alu_op_out(alu_op_out),
    .alu_imm_out(alu_imm_out), .alu_pc_out(alu_pc_out), .alu_rs1val_out(alu_rs1val_out),
    .alu_rs2val_out(alu_rs2val_out), .alu_dest_out(alu_dest_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        disp;
    logic [5:0]  op;
    logic        r1;
    logic [31:0] v1;
    logic [3:0]  t1;
    logic        r2;
    logic [31:0] v2;
    logic [3:0]  t2;
    logic [3:0]  dest;
    logic        ab;
    logic [3:0]  at;
    logic [31:0] av;
    logic        lb;
    logic [3:0]  lt;
    logic [31:0] lv;
    logic        e_calc;
    logic [5:0]  e_op;
    logic [3:0]  e_dest;
    logic [31:0] e_v1;
    logic [31:0] e_v2;
  } vec_t;

  vec_t tbl [21];

  // Immediate and PC are derived from the opcode so issued values are predictable.
  function automatic logic [31:0] imm_of(input logic [5:0] op);
    return 32'h0000_1000 + {26'd0, op};
  endfunction

  function automatic logic [31:0] pc_of(input logic [5:0] op);
    return 32'h0000_4000 + {24'd0, op, 2'b00};
  endfunction

  function automatic vec_t exp_v(input logic c, input logic [5:0] op, input logic [3:0] d,
                                 input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    v = '{default: '0};
    v.e_calc = c;
    v.e_op   = op;
    v.e_dest = d;
    v.e_v1   = a;
    v.e_v2   = b;
    return v;
  endfunction

  function automatic vec_t with_disp(input vec_t vi, input logic [5:0] op,
                                     input logic r1, input logic [31:0] v1, input logic [3:0] t1,
                                     input logic r2, input logic [31:0] v2, input logic [3:0] t2,
                                     input logic [3:0] dest);
    vec_t v;
    v = vi;
    v.disp = 1'b1; v.op = op; v.r1 = r1; v.v1 = v1; v.t1 = t1;
    v.r2 = r2; v.v2 = v2; v.t2 = t2; v.dest = dest;
    return v;
  endfunction

  function automatic vec_t with_alu(input vec_t vi, input logic [3:0] tag, input logic [31:0] val);
    vec_t v;
    v = vi;
    v.ab = 1'b1; v.at = tag; v.av = val;
    return v;
  endfunction

  function automatic vec_t with_lsb(input vec_t vi, input logic [3:0] tag, input logic [31:0] val);
    vec_t v;
    v = vi;
    v.lb = 1'b1; v.lt = tag; v.lv = val;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    dispatch_signal_in      = 1'b0;
    dispatch_op_in          = '0;
    dispatch_imm_in         = '0;
    dispatch_pc_in          = '0;
    dispatch_rs1_ready_in   = 1'b0;
    dispatch_rs1val_in      = '0;
    dispatch_rs1tag_in      = '0;
    dispatch_rs2_ready_in   = 1'b0;
    dispatch_rs2val_in      = '0;
    dispatch_rs2tag_in      = '0;
    dispatch_dest_in        = '0;
    alu_broadcast_signal_in = 1'b0;
    alu_result_in           = '0;
    alu_dest_tag_in         = '0;
    lsb_broadcast_signal_in = 1'b0;
    lsb_result_in           = '0;
    lsb_dest_tag_in         = '0;
  endtask

  task automatic drive_disp(input logic [5:0] op, input logic r1, input logic [31:0] v1,
                            input logic [3:0] t1, input logic r2, input logic [31:0] v2,
                            input logic [3:0] t2, input logic [3:0] dest);
    dispatch_signal_in    = 1'b1;
    dispatch_op_in        = op;
    dispatch_imm_in       = imm_of(op);
    dispatch_pc_in        = pc_of(op);
    dispatch_rs1_ready_in = r1;
    dispatch_rs1val_in    = v1;
    dispatch_rs1tag_in    = t1;
    dispatch_rs2_ready_in = r2;
    dispatch_rs2val_in    = v2;
    dispatch_rs2tag_in    = t2;
    dispatch_dest_in      = dest;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // Table: each row is one cycle of inputs and the outputs expected after that edge.
    tbl[0]  = with_disp(exp_v(1'b0, 6'd0, 4'd0, 32'd0, 32'd0), 6'd1, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd9);
    tbl[1]  = exp_v(1'b1, 6'd1, 4'd9, 32'd5, 32'd7);
    tbl[2]  = with_disp(exp_v(1'b0, 6'd1, 4'd9, 32'd0, 32'd0), 6'd2, 1'b0, 32'd0, 4'd3, 1'b1, 32'd1, 4'd0, 4'd4);
    tbl[3]  = exp_v(1'b0, 6'd1, 4'd9, 32'd0, 32'd0);
    tbl[4]  = with_lsb(exp_v(1'b0, 6'd1, 4'd9, 32'd0, 32'd0), 4'd3, 32'h10);
    tbl[5]  = exp_v(1'b1, 6'd2, 4'd4, 32'h10, 32'd1);
    tbl[6]  = with_alu(with_disp(exp_v(1'b0, 6'd2, 4'd4, 32'd0, 32'd0), 6'd3, 1'b1, 32'h22, 4'd0,
                                 1'b0, 32'd0, 4'd6, 4'd5), 4'd6, 32'hABCD);
    tbl[7]  = exp_v(1'b1, 6'd3, 4'd5, 32'h22, 32'hABCD);
    tbl[8]  = with_lsb(with_alu(with_disp(exp_v(1'b0, 6'd3, 4'd5, 32'd0, 32'd0), 6'd4, 1'b0, 32'd0, 4'd7,
                                          1'b1, 32'd3, 4'd0, 4'd6), 4'd7, 32'h111), 4'd7, 32'h222);
    tbl[9]  = exp_v(1'b1, 6'd4, 4'd6, 32'h111, 32'd3);
    tbl[10] = with_disp(exp_v(1'b0, 6'd4, 4'd6, 32'd0, 32'd0), 6'd5, 1'b0, 32'd0, 4'd8, 1'b0, 32'd0, 4'd8, 4'd7);
    tbl[11] = with_lsb(with_alu(exp_v(1'b0, 6'd4, 4'd6, 32'd0, 32'd0), 4'd8, 32'h5), 4'd8, 32'h6);
    tbl[12] = exp_v(1'b1, 6'd5, 4'd7, 32'h5, 32'h5);
    tbl[13] = with_disp(exp_v(1'b0, 6'd5, 4'd7, 32'd0, 32'd0), 6'd6, 1'b0, 32'd0, 4'd1, 1'b1, 32'd2, 4'd0, 4'd8);
    tbl[14] = with_alu(exp_v(1'b0, 6'd5, 4'd7, 32'd0, 32'd0), 4'd2, 32'h99);
    tbl[15] = with_lsb(exp_v(1'b0, 6'd5, 4'd7, 32'd0, 32'd0), 4'd1, 32'hFFFF_FFFF);
    tbl[16] = exp_v(1'b1, 6'd6, 4'd8, 32'hFFFF_FFFF, 32'd2);
    tbl[17] = with_disp(exp_v(1'b0, 6'd6, 4'd8, 32'd0, 32'd0), 6'd7, 1'b1, 32'hA, 4'd0, 1'b1, 32'hB, 4'd0, 4'd10);
    tbl[18] = with_disp(exp_v(1'b1, 6'd7, 4'd10, 32'hA, 32'hB), 6'd8, 1'b1, 32'hC, 4'd0, 1'b1, 32'hD, 4'd0, 4'd11);
    tbl[19] = exp_v(1'b1, 6'd8, 4'd11, 32'hC, 32'hD);
    tbl[20] = exp_v(1'b0, 6'd8, 4'd11, 32'd0, 32'd0);

    rst_n_in     = 1'b0;
    rdy_in       = 1'b1;
    rob_clear_in = 1'b0;
    idle_inputs();
    #12;
    check("rst.calc", 32'(alu_calculate_signal_out), 32'd0);
    check("rst.op",   32'(alu_op_out), 32'd0);
    check("rst.rs1",  alu_rs1val_out, 32'd0);
    check("rst.full", 32'(full_out), 32'd0);
    rst_n_in = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      idle_inputs();
      if (tbl[i].disp)
        drive_disp(tbl[i].op, tbl[i].r1, tbl[i].v1, tbl[i].t1, tbl[i].r2, tbl[i].v2, tbl[i].t2, tbl[i].dest);
      alu_broadcast_signal_in = tbl[i].ab;
      alu_dest_tag_in         = tbl[i].at;
      alu_result_in           = tbl[i].av;
      lsb_broadcast_signal_in = tbl[i].lb;
      lsb_dest_tag_in         = tbl[i].lt;
      lsb_result_in           = tbl[i].lv;
      step();
      check($sformatf("v%0d.calc", i), 32'(alu_calculate_signal_out), 32'(tbl[i].e_calc));
      check($sformatf("v%0d.op", i),   32'(alu_op_out), 32'(tbl[i].e_op));
      check($sformatf("v%0d.dest", i), 32'(alu_dest_out), 32'(tbl[i].e_dest));
      check($sformatf("v%0d.full", i), 32'(full_out), 32'd0);
      if (tbl[i].e_calc) begin
        check($sformatf("v%0d.rs1", i), alu_rs1val_out, tbl[i].e_v1);
        check($sformatf("v%0d.rs2", i), alu_rs2val_out, tbl[i].e_v2);
        check($sformatf("v%0d.imm", i), alu_imm_out, imm_of(tbl[i].e_op));
        check($sformatf("v%0d.pc", i),  alu_pc_out, pc_of(tbl[i].e_op));
      end
    end

    // rdy_in low freezes state, drops dispatches and forces the issue pulse low.
    idle_inputs();
    drive_disp(6'd9, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0, 4'd12);
    step();
    check("rdy.disp_calc", 32'(alu_calculate_signal_out), 32'd0);
    idle_inputs();
    rdy_in = 1'b0;
    drive_disp(6'd10, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd13);
    step();
    check("rdy.frozen_calc", 32'(alu_calculate_signal_out), 32'd0);
    idle_inputs();
    rdy_in = 1'b1;
    step();
    check("rdy.issue_calc", 32'(alu_calculate_signal_out), 32'd1);
    check("rdy.issue_dest", 32'(alu_dest_out), 32'd12);
    rdy_in = 1'b0;
    step();
    check("rdy.pulse_drop", 32'(alu_calculate_signal_out), 32'd0);
    check("rdy.hold_op", 32'(alu_op_out), 32'd9);
    rdy_in = 1'b1;
    step();
    check("rdy.no_dropped_issue", 32'(alu_calculate_signal_out), 32'd0);

    // Fill all entries waiting on tag 2, overflow dispatch, then drain in order.
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      drive_disp(6'(16 + i), 1'b0, 32'd0, 4'd2, 1'b1, 32'(i), 4'd0, 4'(i));
      step();
      check($sformatf("fill%0d.full", i), 32'(full_out), (i == 7) ? 32'd1 : 32'd0);
    end
    idle_inputs();
    drive_disp(6'd40, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0, 4'd15);
    step();
    check("fill.overflow_calc", 32'(alu_calculate_signal_out), 32'd0);
    check("fill.overflow_full", 32'(full_out), 32'd1);
    idle_inputs();
    lsb_broadcast_signal_in = 1'b1;
    lsb_dest_tag_in         = 4'd2;
    lsb_result_in           = 32'h77;
    step();
    check("fill.wake_calc", 32'(alu_calculate_signal_out), 32'd0);
    check("fill.wake_full", 32'(full_out), 32'd1);
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("drain%0d.calc", i), 32'(alu_calculate_signal_out), 32'd1);
      check($sformatf("drain%0d.dest", i), 32'(alu_dest_out), 32'(i));
      check($sformatf("drain%0d.rs1", i),  alu_rs1val_out, 32'h77);
      check($sformatf("drain%0d.rs2", i),  alu_rs2val_out, 32'(i));
      check($sformatf("drain%0d.full", i), 32'(full_out), 32'd0);
    end
    step();
    check("drain.empty_calc", 32'(alu_calculate_signal_out), 32'd0);

    // Flush with four woken entries, a same-cycle dispatch and a pending select.
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      drive_disp(6'(32 + i), 1'b0, 32'd0, 4'd5, 1'b1, 32'd1, 4'd0, 4'(i));
      step();
    end
    idle_inputs();
    step();
    check("flush.waiting_calc", 32'(alu_calculate_signal_out), 32'd0);
    lsb_broadcast_signal_in = 1'b1;
    lsb_dest_tag_in         = 4'd5;
    lsb_result_in           = 32'h55;
    step();
    check("flush.wake_calc", 32'(alu_calculate_signal_out), 32'd0);
    idle_inputs();
    rob_clear_in = 1'b1;
    drive_disp(6'd20, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd14);
    step();
    check("flush.calc", 32'(alu_calculate_signal_out), 32'd0);
    check("flush.full", 32'(full_out), 32'd0);
    rob_clear_in = 1'b0;
    idle_inputs();
    lsb_broadcast_signal_in = 1'b1;
    lsb_dest_tag_in         = 4'd5;
    lsb_result_in           = 32'h55;
    step();
    check("flush.post_bc_calc", 32'(alu_calculate_signal_out), 32'd0);
    idle_inputs();
    step();
    check("flush.post1_calc", 32'(alu_calculate_signal_out), 32'd0);
    step();
    check("flush.post2_calc", 32'(alu_calculate_signal_out), 32'd0);

    // Asynchronous reset while an issue pulse is high.
    drive_disp(6'd33, 1'b1, 32'h5A, 4'd0, 1'b1, 32'hA5, 4'd0, 4'd3);
    step();
    idle_inputs();
    step();
    check("areset.pre_calc", 32'(alu_calculate_signal_out), 32'd1);
    check("areset.pre_op", 32'(alu_op_out), 32'd33);
    drive_disp(6'd34, 1'b1, 32'h1, 4'd0, 1'b1, 32'h2, 4'd0, 4'd4);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("areset.calc", 32'(alu_calculate_signal_out), 32'd0);
    check("areset.op",   32'(alu_op_out), 32'd0);
    check("areset.rs1",  alu_rs1val_out, 32'd0);
    check("areset.rs2",  alu_rs2val_out, 32'd0);
    check("areset.pc",   alu_pc_out, 32'd0);
    check("areset.dest", 32'(alu_dest_out), 32'd0);
    idle_inputs();
    #1;
    rst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("areset.post%0d_calc", i), 32'(alu_calculate_signal_out), 32'd0);
    end
    check("areset.post_full", 32'(full_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
